ladybird_axi_arbiter: RTL and testbench

LADYBIRD_AXI_ARBITER -- requirements
Module: ladybird_axi_arbiter

---
 rtl/ladybird_axi_pkg.sv | 15 +
 rtl/ladybird_axi_if.sv | 49 ++++
 rtl/ladybird_rr_select.sv | 20 ++
 rtl/ladybird_axi_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ladybird_axi_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_axi_pkg.sv
// Shared AXI definitions for the ladybird memory subsystem: field widths and
// the arbiter state encoding used by arbiters and debug monitors.
package ladybird_axi;

    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ       = 2'd1,
        WRITE_DATA = 2'd2,
        WRITE_RESP = 2'd3
    } ladybird_axi_arb_state_t;

endpackage

// File: rtl/ladybird_axi_if.sv
// Five-channel AXI bundle; the master modport drives requests, the slave
// modport drives readies and responses.
interface ladybird_axi_interface #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4
);
    logic [AXI_ID_W-1:0]             awid;
    logic [AXI_ADDR_W-1:0]           awaddr;
    logic [ladybird_axi::LEN_W-1:0]  awlen;
    logic [ladybird_axi::SIZE_W-1:0] awsize;
    logic                            awvalid;
    logic                            awready;
    logic [AXI_DATA_W-1:0]           wdata;
    logic [AXI_DATA_W/8-1:0]         wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;
    logic [AXI_ID_W-1:0]             bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [AXI_ID_W-1:0]             arid;
    logic [AXI_ADDR_W-1:0]           araddr;
    logic [ladybird_axi::LEN_W-1:0]  arlen;
    logic [ladybird_axi::SIZE_W-1:0] arsize;
    logic                            arvalid;
    logic                            arready;
    logic [AXI_ID_W-1:0]             rid;
    logic [AXI_DATA_W-1:0]           rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid,
               bready, arid, araddr, arlen, arsize, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
               rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid,
               bready, arid, araddr, arlen, arsize, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
               rlast, rvalid
    );
endinterface

// File: rtl/ladybird_rr_select.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last. Output is one-hot or zero.
module ladybird_rr_select (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Priority decode of the request pair against the previous winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ladybird_axi_arbiter.sv
// Two-master AXI arbiter with a single transaction in flight; the granted
// master is routed to the downstream bus combinationally with no added latency.
module ladybird_axi_arbiter #(
    parameter int NUM_OUTSTANDING = 1
) (
    input logic                   clk,
    input logic                   nrst,
    ladybird_axi_interface.slave  s0,
    ladybird_axi_interface.slave  s1,
    ladybird_axi_interface.master m
);
    import ladybird_axi::*;

    if (NUM_OUTSTANDING != 1) begin : g_bad_outstanding
        $error("ladybird_axi_arbiter supports only NUM_OUTSTANDING == 1");
    end

    ladybird_axi_arb_state_t state_r, state_nxt_s;
    logic       grant_r, grant_nxt_s;
    logic       last_grant_r, last_grant_nxt_s;
    logic [1:0] req_s, gnt_s;
    logic       sel_s;
    logic       sel_awvalid_s, sel_arvalid_s, sel_wvalid_s, sel_rready_s, sel_bready_s;
    logic       aw_go_s, ar_go_s, aw_fire_s, ar_fire_s;
    logic       w_last_fire_s, r_last_fire_s, b_fire_s;

    assign req_s = {s1.awvalid | s1.arvalid, s0.awvalid | s0.arvalid};

    ladybird_rr_select u_rr_select (
        .req        (req_s),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    // While idle the live arbitration result steers the muxes; afterwards the held grant does
    assign sel_s         = (state_r == IDLE) ? gnt_s[1] : grant_r;
    assign sel_awvalid_s = sel_s ? s1.awvalid : s0.awvalid;
    assign sel_arvalid_s = sel_s ? s1.arvalid : s0.arvalid;
    assign sel_wvalid_s  = sel_s ? s1.wvalid  : s0.wvalid;
    assign sel_rready_s  = sel_s ? s1.rready  : s0.rready;
    assign sel_bready_s  = sel_s ? s1.bready  : s0.bready;

    assign aw_go_s       = (state_r == IDLE) & (gnt_s != 2'b00) & sel_awvalid_s;
    assign ar_go_s       = (state_r == IDLE) & (gnt_s != 2'b00) & ~sel_awvalid_s & sel_arvalid_s;
    assign aw_fire_s     = aw_go_s & m.awready;
    assign ar_fire_s     = ar_go_s & m.arready;
    assign w_last_fire_s = (state_r == WRITE_DATA) & sel_wvalid_s & m.wready & m.wlast;
    assign r_last_fire_s = (state_r == READ) & m.rvalid & sel_rready_s & m.rlast;
    assign b_fire_s      = (state_r == WRITE_RESP) & m.bvalid & sel_bready_s;

    assign m.awid   = sel_s ? s1.awid   : s0.awid;
    assign m.awaddr = sel_s ? s1.awaddr : s0.awaddr;
    assign m.awlen  = sel_s ? s1.awlen  : s0.awlen;
    assign m.awsize = sel_s ? s1.awsize : s0.awsize;
    assign m.wdata  = sel_s ? s1.wdata  : s0.wdata;
    assign m.wstrb  = sel_s ? s1.wstrb  : s0.wstrb;
    assign m.wlast  = sel_s ? s1.wlast  : s0.wlast;
    assign m.arid   = sel_s ? s1.arid   : s0.arid;
    assign m.araddr = sel_s ? s1.araddr : s0.araddr;
    assign m.arlen  = sel_s ? s1.arlen  : s0.arlen;
    assign m.arsize = sel_s ? s1.arsize : s0.arsize;

    assign s0.bid   = m.bid;
    assign s0.bresp = m.bresp;
    assign s0.rid   = m.rid;
    assign s0.rdata = m.rdata;
    assign s0.rresp = m.rresp;
    assign s0.rlast = m.rlast;
    assign s1.bid   = m.bid;
    assign s1.bresp = m.bresp;
    assign s1.rid   = m.rid;
    assign s1.rdata = m.rdata;
    assign s1.rresp = m.rresp;
    assign s1.rlast = m.rlast;

    // State, held grant and round-robin history
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Next state: leave IDLE only on a downstream address handshake
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (aw_fire_s) begin
                    state_nxt_s      = WRITE_DATA;
                    grant_nxt_s      = gnt_s[1];
                    last_grant_nxt_s = gnt_s[1];
                end else if (ar_fire_s) begin
                    state_nxt_s      = READ;
                    grant_nxt_s      = gnt_s[1];
                    last_grant_nxt_s = gnt_s[1];
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (r_last_fire_s) state_nxt_s = IDLE;
                else               state_nxt_s = READ;
            end
            WRITE_DATA: begin
                if (w_last_fire_s) state_nxt_s = WRITE_RESP;
                else               state_nxt_s = WRITE_DATA;
            end
            WRITE_RESP: begin
                if (b_fire_s) state_nxt_s = IDLE;
                else          state_nxt_s = WRITE_RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake routing: only the channel matching the state is opened, only toward the grant
    always_comb begin
        m.awvalid  = 1'b0;
        m.arvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        m.rready   = 1'b0;
        s0.awready = 1'b0;
        s0.arready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.rvalid  = 1'b0;
        s1.awready = 1'b0;
        s1.arready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.rvalid  = 1'b0;
        case (state_r)
            IDLE: begin
                m.awvalid  = aw_go_s;
                m.arvalid  = ar_go_s;
                s0.awready = ~sel_s & aw_go_s & m.awready;
                s1.awready =  sel_s & aw_go_s & m.awready;
                s0.arready = ~sel_s & ar_go_s & m.arready;
                s1.arready =  sel_s & ar_go_s & m.arready;
            end
            READ: begin
                m.rready  = sel_rready_s;
                s0.rvalid = ~sel_s & m.rvalid;
                s1.rvalid =  sel_s & m.rvalid;
            end
            WRITE_DATA: begin
                m.wvalid  = sel_wvalid_s;
                s0.wready = ~sel_s & m.wready;
                s1.wready =  sel_s & m.wready;
            end
            WRITE_RESP: begin
                m.bready  = sel_bready_s;
                s0.bvalid = ~sel_s & m.bvalid;
                s1.bvalid =  sel_s & m.bvalid;
            end
            default: m.awvalid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ladybird_axi_arbiter.sv
// Directed scoreboard bench for ladybird_axi_arbiter: two driven masters, a
// small memory model on the downstream side, and a response monitor.
module tb_ladybird_axi_arbiter;
    import ladybird_axi::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ladybird_axi_interface #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4)) s0_if ();
    ladybird_axi_interface #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4)) s1_if ();
    ladybird_axi_interface #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4)) m_if ();

    ladybird_axi_arbiter #(.NUM_OUTSTANDING(1)) dut (
        .clk  (clk),
        .nrst (nrst),
        .s0   (s0_if),
        .s1   (s1_if),
        .m    (m_if)
    );

    // Upstream master drive variables, index 0 = s0, 1 = s1
    logic [1:0]  t_awvalid, t_arvalid, t_wvalid, t_wlast;
    logic [31:0] t_awaddr [2];
    logic [31:0] t_araddr [2];
    logic [31:0] t_wdata  [2];
    logic [7:0]  t_awlen  [2];
    logic [7:0]  t_arlen  [2];
    logic [3:0]  t_awid   [2];
    logic [3:0]  t_arid   [2];

    assign s0_if.awvalid = t_awvalid[0];  assign s1_if.awvalid = t_awvalid[1];
    assign s0_if.awid    = t_awid[0];     assign s1_if.awid    = t_awid[1];
    assign s0_if.awaddr  = t_awaddr[0];   assign s1_if.awaddr  = t_awaddr[1];
    assign s0_if.awlen   = t_awlen[0];    assign s1_if.awlen   = t_awlen[1];
    assign s0_if.awsize  = 3'd2;          assign s1_if.awsize  = 3'd2;
    assign s0_if.wdata   = t_wdata[0];    assign s1_if.wdata   = t_wdata[1];
    assign s0_if.wstrb   = 4'hF;          assign s1_if.wstrb   = 4'hF;
    assign s0_if.wlast   = t_wlast[0];    assign s1_if.wlast   = t_wlast[1];
    assign s0_if.wvalid  = t_wvalid[0];   assign s1_if.wvalid  = t_wvalid[1];
    assign s0_if.arvalid = t_arvalid[0];  assign s1_if.arvalid = t_arvalid[1];
    assign s0_if.arid    = t_arid[0];     assign s1_if.arid    = t_arid[1];
    assign s0_if.araddr  = t_araddr[0];   assign s1_if.araddr  = t_araddr[1];
    assign s0_if.arlen   = t_arlen[0];    assign s1_if.arlen   = t_arlen[1];
    assign s0_if.arsize  = 3'd2;          assign s1_if.arsize  = 3'd2;
    assign s0_if.rready  = 1'b1;          assign s1_if.rready  = 1'b1;
    assign s0_if.bready  = 1'b1;          assign s1_if.bready  = 1'b1;

    wire [1:0] u_awready = {s1_if.awready, s0_if.awready};
    wire [1:0] u_arready = {s1_if.arready, s0_if.arready};
    wire [1:0] u_wready  = {s1_if.wready,  s0_if.wready};
    wire [1:0] u_rvalid  = {s1_if.rvalid,  s0_if.rvalid};
    wire [1:0] u_bvalid  = {s1_if.bvalid,  s0_if.bvalid};
    wire [1:0] u_rlast   = {s1_if.rlast,   s0_if.rlast};
    logic [31:0] u_rdata [2];
    logic [3:0]  u_rid   [2];
    logic [3:0]  u_bid   [2];
    assign u_rdata[0] = s0_if.rdata;  assign u_rdata[1] = s1_if.rdata;
    assign u_rid[0]   = s0_if.rid;    assign u_rid[1]   = s1_if.rid;
    assign u_bid[0]   = s0_if.bid;    assign u_bid[1]   = s1_if.bid;

    // Downstream memory model drive variables
    logic        mm_bvalid, mm_rvalid, mm_rlast;
    logic [3:0]  mm_bid, mm_rid, mm_wid;
    logic [31:0] mm_rdata, mm_raddr, mm_waddr;
    logic [7:0]  mm_rcnt;
    logic [31:0] mem [logic [31:0]];

    assign m_if.awready = 1'b1;
    assign m_if.wready  = 1'b1;
    assign m_if.arready = 1'b1;
    assign m_if.bvalid  = mm_bvalid;
    assign m_if.bid     = mm_bid;
    assign m_if.bresp   = 2'b00;
    assign m_if.rvalid  = mm_rvalid;
    assign m_if.rid     = mm_rid;
    assign m_if.rdata   = mm_rdata;
    assign m_if.rresp   = 2'b00;
    assign m_if.rlast   = mm_rlast;

    typedef struct {
        logic        kind;   // 0 = R beat, 1 = B response
        int          idx;
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic txn_open = 1'b0;
    int   cyc = 0;
    int   b_cyc = 0;
    int   ar_cyc [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return {16'hD00D, addr[15:0]};
    endfunction

    // Memory model: sample handshakes mid-cycle, update responses just after the edge
    initial begin : mem_model
        logic f_aw, f_w, f_b, f_ar, f_r, s_wlast;
        logic [31:0] s_awaddr, s_araddr, s_wdata;
        logic [7:0]  s_arlen;
        logic [3:0]  s_awid, s_arid;
        mm_bvalid = 1'b0; mm_rvalid = 1'b0; mm_rlast = 1'b0;
        mm_bid = 4'd0; mm_rid = 4'd0; mm_wid = 4'd0;
        mm_rdata = 32'd0; mm_raddr = 32'd0; mm_waddr = 32'd0; mm_rcnt = 8'd0;
        forever begin
            @(negedge clk);
            f_aw = nrst & m_if.awvalid & m_if.awready;
            f_w  = nrst & m_if.wvalid & m_if.wready;
            f_b  = nrst & m_if.bvalid & m_if.bready;
            f_ar = nrst & m_if.arvalid & m_if.arready;
            f_r  = nrst & m_if.rvalid & m_if.rready;
            s_awaddr = m_if.awaddr; s_awid = m_if.awid;
            s_wdata = m_if.wdata;   s_wlast = m_if.wlast;
            s_araddr = m_if.araddr; s_arlen = m_if.arlen; s_arid = m_if.arid;
            @(posedge clk);
            #1;
            if (!nrst) begin
                mm_bvalid = 1'b0; mm_rvalid = 1'b0; mm_rlast = 1'b0;
            end else begin
                if (f_aw) begin mm_waddr = s_awaddr; mm_wid = s_awid; end
                if (f_w) begin
                    mem[mm_waddr] = s_wdata;
                    mm_waddr = mm_waddr + 32'd4;
                    if (s_wlast) begin mm_bvalid = 1'b1; mm_bid = mm_wid; end
                end
                if (f_b) mm_bvalid = 1'b0;
                if (f_r) begin
                    if (mm_rlast) mm_rvalid = 1'b0;
                    else begin
                        mm_raddr = mm_raddr + 32'd4;
                        mm_rcnt  = mm_rcnt - 8'd1;
                        mm_rdata = rd_word(mm_raddr);
                        mm_rlast = (mm_rcnt == 8'd0);
                    end
                end
                if (f_ar) begin
                    mm_raddr = s_araddr; mm_rcnt = s_arlen; mm_rid = s_arid;
                    mm_rvalid = 1'b1; mm_rdata = rd_word(s_araddr);
                    mm_rlast = (s_arlen == 8'd0);
                end
            end
        end
    end

    task automatic push(input logic kind, input int idx, input logic [31:0] data,
                        input logic last, input logic [3:0] id);
        exp_t e;
        e.kind = kind; e.idx = idx; e.data = data; e.last = last; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic check_resp(input logic kind, input int idx, input logic [31:0] data,
                              input logic last, input logic [3:0] id);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp: m%0d kind=%0d data=%h last=%0d, expected no response",
                     idx, kind, data, last);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.idx != idx || e.data !== data || e.last !== last || e.id !== id) begin
                miscompares++;
                $display("FAIL resp: got m%0d kind=%0d data=%h last=%0d id=%0d, expected m%0d kind=%0d data=%h last=%0d id=%0d",
                         idx, kind, data, last, id, e.idx, e.kind, e.data, e.last, e.id);
            end
        end
        if (kind || last) txn_open = 1'b0;
        if (kind) b_cyc = cyc;
    endtask

    // Monitor: pop and compare every upstream response; flag overlapping transactions
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (nrst) begin
                for (int i = 0; i < 2; i++) begin
                    if (u_rvalid[i]) check_resp(1'b0, i, u_rdata[i], u_rlast[i], u_rid[i]);
                    if (u_bvalid[i]) check_resp(1'b1, i, 32'h0, 1'b1, u_bid[i]);
                end
                for (int i = 0; i < 2; i++) begin
                    if ((u_awready[i] & t_awvalid[i]) | (u_arready[i] & t_arvalid[i])) begin
                        vectors++;
                        if (txn_open) begin
                            miscompares++;
                            $display("FAIL overlap: m%0d address accepted while a transaction was open, expected wait for completion", i);
                        end
                        txn_open = 1'b1;
                        ar_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int i);
        vectors++;
        miscompares++;
        $display("FAIL %s: m%0d ready stayed 0, expected 1 within 200 cycles", name, i);
    endtask

    task automatic set_ar(input int i, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        t_araddr[i] = addr; t_arlen[i] = len; t_arid[i] = id; t_arvalid[i] = 1'b1;
    endtask

    task automatic wait_ar(input int i);
        @(negedge clk);
        for (int n = 0; n < 200 && !u_arready[i]; n++) @(negedge clk);
        if (!u_arready[i]) timeout_fail("ar_timeout", i);
        @(posedge clk); #1;
        t_arvalid[i] = 1'b0;
    endtask

    task automatic issue_read(input int i, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        set_ar(i, addr, len, id);
        wait_ar(i);
    endtask

    task automatic issue_write(input int i, input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] id);
        t_awaddr[i] = addr; t_awlen[i] = len; t_awid[i] = id; t_awvalid[i] = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 200 && !u_awready[i]; n++) @(negedge clk);
        if (!u_awready[i]) timeout_fail("aw_timeout", i);
        @(posedge clk); #1;
        t_awvalid[i] = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t_wdata[i] = (b == 0) ? d0 : d1;
            t_wlast[i] = (b == int'(len));
            t_wvalid[i] = 1'b1;
            @(negedge clk);
            for (int n = 0; n < 200 && !u_wready[i]; n++) @(negedge clk);
            if (!u_wready[i]) timeout_fail("w_timeout", i);
            @(posedge clk); #1;
        end
        t_wvalid[i] = 1'b0;
        t_wlast[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || txn_open) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || txn_open) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
            txn_open = 1'b0;
        end
    endtask

    initial begin : stimulus
        int n;
        t_awvalid = 2'b00; t_arvalid = 2'b00; t_wvalid = 2'b00; t_wlast = 2'b00;
        for (int i = 0; i < 2; i++) begin
            t_awaddr[i] = 32'd0; t_araddr[i] = 32'd0; t_wdata[i] = 32'd0;
            t_awlen[i] = 8'd0; t_arlen[i] = 8'd0; t_awid[i] = 4'd0; t_arid[i] = 4'd0;
            ar_cyc[i] = 0;
        end

        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        chk("rst_grant", 32'(dut.grant_r), 32'd0);
        chk("rst_last_grant", 32'(dut.last_grant_r), 32'd1);
        chk("rst_m_valid_ready", 32'({m_if.awvalid, m_if.arvalid, m_if.wvalid, m_if.rready, m_if.bready}), 32'd0);
        chk("rst_up_ready", 32'({u_awready, u_arready, u_wready, u_rvalid, u_bvalid}), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Simultaneous reads after reset: s0 first, then s1
        push(1'b0, 0, 32'hD00D_0200, 1'b0, 4'd1);
        push(1'b0, 0, 32'hD00D_0204, 1'b1, 4'd1);
        push(1'b0, 1, 32'hD00D_0300, 1'b1, 4'd2);
        fork
            issue_read(0, 32'h200, 8'd1, 4'd1);
            issue_read(1, 32'h300, 8'd0, 4'd2);
        join
        wait_drain();
        chk("tie1_last_grant", 32'(dut.last_grant_r), 32'd1);

        push(1'b0, 0, 32'hD00D_0210, 1'b1, 4'd1);
        push(1'b0, 1, 32'hD00D_0310, 1'b1, 4'd2);
        fork
            issue_read(0, 32'h210, 8'd0, 4'd1);
            issue_read(1, 32'h310, 8'd0, 4'd2);
        join
        wait_drain();

        // s0 alone, then a tie must go to s1
        push(1'b0, 0, 32'hD00D_0220, 1'b1, 4'd1);
        issue_read(0, 32'h220, 8'd0, 4'd1);
        wait_drain();
        chk("solo_s0_last_grant", 32'(dut.last_grant_r), 32'd0);
        push(1'b0, 1, 32'hD00D_0320, 1'b1, 4'd2);
        push(1'b0, 0, 32'hD00D_0230, 1'b1, 4'd1);
        fork
            issue_read(0, 32'h230, 8'd0, 4'd1);
            issue_read(1, 32'h320, 8'd0, 4'd2);
        join
        wait_drain();

        // s1 four-beat read alone
        push(1'b0, 1, 32'hD00D_0100, 1'b0, 4'd2);
        push(1'b0, 1, 32'hD00D_0104, 1'b0, 4'd2);
        push(1'b0, 1, 32'hD00D_0108, 1'b0, 4'd2);
        push(1'b0, 1, 32'hD00D_010C, 1'b1, 4'd2);
        issue_read(1, 32'h100, 8'd3, 4'd2);
        wait_drain();
        chk("s1_read_last_grant", 32'(dut.last_grant_r), 32'd1);

        // s0 writes two beats, s1 reads them back
        push(1'b1, 0, 32'h0, 1'b1, 4'd1);
        issue_write(0, 32'h40, 8'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd1);
        wait_drain();
        push(1'b0, 1, 32'hA5A5_A5A5, 1'b0, 4'd2);
        push(1'b0, 1, 32'h5A5A_5A5A, 1'b1, 4'd2);
        issue_read(1, 32'h40, 8'd1, 4'd2);
        wait_drain();

        // s1 raises AW and AR together: write completes before the read
        push(1'b1, 1, 32'h0, 1'b1, 4'd3);
        push(1'b0, 1, 32'hD00D_0500, 1'b1, 4'd3);
        set_ar(1, 32'h500, 8'd0, 4'd3);
        issue_write(1, 32'h60, 8'd0, 32'h1234_5678, 32'h0, 4'd3);
        wait_ar(1);
        wait_drain();

        // s1 read arrives during s0's write burst
        push(1'b1, 0, 32'h0, 1'b1, 4'd1);
        push(1'b0, 1, 32'hCAFE_0001, 1'b1, 4'd2);
        fork
            issue_write(0, 32'h80, 8'd1, 32'hCAFE_0001, 32'hCAFE_0002, 4'd1);
            begin
                repeat (2) @(posedge clk);
                #1;
                issue_read(1, 32'h80, 8'd0, 4'd2);
            end
        join
        wait_drain();
        chk("ar_cycle_after_b", 32'(ar_cyc[1] - b_cyc), 32'd1);

        // Reset while beat 2 of a 4-beat read is on the bus
        push(1'b0, 0, 32'hD00D_0100, 1'b0, 4'd1);
        issue_read(0, 32'h100, 8'd3, 4'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("beat1_before_reset", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dut.state_r), 32'(IDLE));
        chk("mid_rst_up_rvalid", 32'(u_rvalid), 32'd0);
        chk("mid_rst_m_valid_ready", 32'({m_if.awvalid, m_if.arvalid, m_if.wvalid, m_if.rready, m_if.bready}), 32'd0);
        chk("mid_rst_up_ready", 32'({u_awready, u_arready, u_wready, u_bvalid}), 32'd0);
        exp_q.delete();
        txn_open = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("post_rst_last_grant", 32'(dut.last_grant_r), 32'd1);
        chk("post_rst_grant", 32'(dut.grant_r), 32'd0);
        @(posedge clk); #1;
        push(1'b0, 0, 32'hD00D_0100, 1'b0, 4'd1);
        push(1'b0, 0, 32'hD00D_0104, 1'b0, 4'd1);
        push(1'b0, 0, 32'hD00D_0108, 1'b0, 4'd1);
        push(1'b0, 0, 32'hD00D_010C, 1'b1, 4'd1);
        issue_read(0, 32'h100, 8'd3, 4'd1);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
